// File: rtl/frame_swap_scheduler_pkg.sv
// Shared state type and sizing defaults for the frame swap scheduler.
// Default geometry comes from COLOR_BITS / ADDR_BITS when the build defines them.
`ifndef COLOR_BITS
`define COLOR_BITS 12
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

package frame_swap_scheduler_pkg;
  typedef enum logic [1:0] {ST_RENDER, ST_WAIT_VSYNC, ST_ARMED} frame_swap_state_t;
  localparam int STATS_WIDTH  = 16;
  localparam int DEF_WIDTH    = `COLOR_BITS;
  localparam int DEF_ADDR_LEN = `ADDR_BITS;
endpackage

// File: rtl/frame_swap_scheduler_rising_edge_detector.sv
// Registers a level and flags the cycle in which it goes from low to high.
module rising_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);
  logic in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;
endmodule

// File: rtl/frame_swap_scheduler.sv
// Writes the renderer pixel stream into the back frame buffer and swaps buffers at vsync.
// Optional swap statistics (frame_count, missed_vsync) are built when SWAP_STATS_EN is defined.
module frame_swap_scheduler
  import frame_swap_scheduler_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_LEN   = DEF_ADDR_LEN,
  parameter int NUM_PIXELS = 1 << DEF_ADDR_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   px_valid,
  input  logic [WIDTH-1:0]       px_data,
  output logic                   px_ready,
  input  logic                   vsync,
  output logic                   write_enable,
  output logic [ADDR_LEN-1:0]    write_addr,
  output logic [WIDTH-1:0]       write_data,
  output logic                   swap_buffers
`ifdef SWAP_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] frame_count,
  output logic [STATS_WIDTH-1:0] missed_vsync
`endif
);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(NUM_PIXELS - 1);

  frame_swap_state_t   state, state_next;
  logic [ADDR_LEN-1:0] addr_cnt;
  logic                vs_rise;
  logic                accept;
  logic                last_px;

  rising_edge_detector u_vsync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (vsync),
    .rise (vs_rise)
  );

  assign px_ready = (state != ST_WAIT_VSYNC);
  assign accept   = px_valid && px_ready;
  assign last_px  = (addr_cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RENDER;
    else        state <= state_next;
  end

  // A vsync edge landing on the last accept of a frame is consumed immediately.
  always_comb begin
    state_next = state;
    case (state)
      ST_RENDER:     if (accept && last_px) state_next = vs_rise ? ST_ARMED : ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vs_rise) state_next = ST_ARMED;
      ST_ARMED:      if (accept) state_next = ST_RENDER;
      default:       state_next = ST_RENDER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt     <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      swap_buffers <= 1'b0;
    end else begin
      write_enable <= accept;
      swap_buffers <= accept && (state == ST_ARMED);
      if (accept) begin
        addr_cnt   <= last_px ? '0 : addr_cnt + 1'b1;
        write_addr <= addr_cnt;
        write_data <= px_data;
      end
    end
  end

`ifdef SWAP_STATS_EN
  // An edge counts as missed unless it is the one that arms the next swap.
  logic missed_edge;
  assign missed_edge = vs_rise &&
                       ((state == ST_ARMED) || ((state == ST_RENDER) && !(accept && last_px)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count  <= '0;
      missed_vsync <= '0;
    end else begin
      if (swap_buffers) frame_count <= frame_count + 1'b1;
      if (missed_edge && (missed_vsync != '1)) missed_vsync <= missed_vsync + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Directed bench for frame_swap_scheduler with a write scoreboard checked on the falling edge.
module tb_frame_swap_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        px_valid = 1'b0;
  logic        vsync = 1'b0;
  logic [11:0] px_data = '0;
  logic        px_ready;
  logic        write_enable;
  logic [3:0]  write_addr;
  logic [11:0] write_data;
  logic        swap_buffers;
`ifdef SWAP_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] missed_vsync;
`endif

  frame_swap_scheduler #(.WIDTH(12), .ADDR_LEN(4), .NUM_PIXELS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .px_valid    (px_valid),
    .px_data     (px_data),
    .px_ready    (px_ready),
    .vsync       (vsync),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .swap_buffers(swap_buffers)
`ifdef SWAP_STATS_EN
    ,
    .frame_count (frame_count),
    .missed_vsync(missed_vsync)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [11:0] data;
    logic        swap;
    int          cyc;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [3:0] exp_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(write_enable), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("write_addr", 32'(write_addr), 32'(mon_e.addr));
        chk("write_data", 32'(write_data), 32'(mon_e.data));
        chk("swap_on_write", 32'(swap_buffers), 32'(mon_e.swap));
        chk("write_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      chk("swap_without_write", 32'(swap_buffers), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d, input logic swap, input logic vs);
    px_valid = 1'b1;
    px_data  = d;
    vsync    = vs;
    chk("px_ready_on_send", 32'(px_ready), 32'd1);
    sb.push_back('{exp_addr, d, swap, cyc + 1});
    exp_addr = exp_addr + 4'd1;
    step();
    px_valid = 1'b0;
    vsync    = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held
    step();
    step();
    chk("rst_px_ready", 32'(px_ready), 32'd1);
    chk("rst_write_enable", 32'(write_enable), 32'd0);
    chk("rst_swap", 32'(swap_buffers), 32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    rst_n = 1'b1;
    step();

    // first frame: no swap, then stall waiting for vsync
    for (int i = 0; i < 16; i++) send(12'(i), 1'b0, 1'b0);
    chk("ready_after_frame", 32'(px_ready), 32'd0);
    px_valid = 1'b1;
    px_data  = 12'hABC;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ready_wait_vsync", 32'(px_ready), 32'd0);
    end
    px_valid = 1'b0;
    pulse_vsync();
    chk("ready_armed", 32'(px_ready), 32'd1);

    // second frame starts with the swap; last pixel coincides with a vsync edge
    send(12'h100, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) send(12'h100 + 12'(i), 1'b0, 1'b0);
    send(12'h10F, 1'b0, 1'b1);
    chk("ready_coincident", 32'(px_ready), 32'd1);
    step();
    step();
    chk("ready_armed_idle", 32'(px_ready), 32'd1);

    // third frame: swap without another vsync, then reset after 7 writes
    send(12'h200, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) send(12'h200 + 12'(i), 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_write_enable", 32'(write_enable), 32'd0);
    chk("midrst_write_addr", 32'(write_addr), 32'd0);
    chk("midrst_write_data", 32'(write_data), 32'd0);
    chk("midrst_px_ready", 32'(px_ready), 32'd1);
    exp_addr = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) send(12'h300 + 12'(i), 1'b0, 1'b0);
    chk("ready_after_restart_frame", 32'(px_ready), 32'd0);

`ifdef SWAP_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    exp_addr = '0;
    chk("stats_rst_frames", 32'(frame_count), 32'd0);
    chk("stats_rst_missed", 32'(missed_vsync), 32'd0);
    for (int i = 0; i < 8; i++) send(12'h400 + 12'(i), 1'b0, 1'b0);
    pulse_vsync();
    for (int i = 8; i < 16; i++) send(12'h400 + 12'(i), 1'b0, 1'b0);
    pulse_vsync();
    send(12'h500, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) send(12'h500 + 12'(i), 1'b0, 1'b0);
    pulse_vsync();
    for (int i = 8; i < 16; i++) send(12'h500 + 12'(i), 1'b0, 1'b0);
    pulse_vsync();
    send(12'h600, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) send(12'h600 + 12'(i), 1'b0, 1'b0);
    step();
    chk("stats_frame_count", 32'(frame_count), 32'd2);
    chk("stats_missed_vsync", 32'(missed_vsync), 32'd2);
    pulse_vsync();
    chk("stats_arm_not_missed", 32'(missed_vsync), 32'd2);
    force dut.missed_vsync = 16'hFFFC;
    step();
    release dut.missed_vsync;
    for (int i = 0; i < 5; i++) pulse_vsync();
    chk("stats_missed_saturate", 32'(missed_vsync), 32'hFFFF);
`endif

    for (int i = 0; i < 4 && sb.size() != 0; i++) step();
    step();
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
